// File: rtl/acc_addr_gen.sv
// Multi-channel wrapping address generator for accumulator buffers: each channel counts
// from a programmed base over a wrap length of up to MATRIX_WIDTH entries.
// Optional feature: define ACC_ADDR_GEN_WRAP_CNT_EN to add saturating per-channel wrap counters (wrap_cnt).
module acc_addr_gen #(
    parameter int COUNTER_WIDTH = 32,
    parameter int MATRIX_WIDTH  = 14,
    parameter int NUM_CH        = 2,
    localparam int LCH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int LEN_W        = $clog2(MATRIX_WIDTH) + 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            enable,
    input  logic                            clear,
    input  logic                            load,
    input  logic [LCH_W-1:0]                load_ch,
    input  logic [COUNTER_WIDTH-1:0]        start_val,
    input  logic [LEN_W-1:0]                len,
    output logic [NUM_CH*COUNTER_WIDTH-1:0] ctr_val,
    output logic [NUM_CH-1:0]               armed,
`ifdef ACC_ADDR_GEN_WRAP_CNT_EN
    output logic [NUM_CH*16-1:0]            wrap_cnt,
`endif
    output logic [NUM_CH-1:0]               wrap
);

    localparam int CW = COUNTER_WIDTH;

    logic [CW-1:0]    base_q  [NUM_CH];
    logic [CW-1:0]    base_d  [NUM_CH];
    logic [LEN_W-1:0] len_q   [NUM_CH];
    logic [LEN_W-1:0] len_d   [NUM_CH];
    logic [CW-1:0]    ctr_q   [NUM_CH];
    logic [CW-1:0]    ctr_d   [NUM_CH];
    logic [NUM_CH-1:0] armed_q;
    logic [NUM_CH-1:0] armed_d;
    logic [NUM_CH-1:0] wrap_q;
    logic [NUM_CH-1:0] wrap_d;
`ifdef ACC_ADDR_GEN_WRAP_CNT_EN
    logic [15:0]      cnt_q   [NUM_CH];
    logic [15:0]      cnt_d   [NUM_CH];
`endif

    logic [LEN_W-1:0] eff_len_in;
    logic [CW-1:0]    last_addr [NUM_CH];
    logic [NUM_CH-1:0] load_hit;
    logic [NUM_CH-1:0] wrap_evt;

    // Zero or oversized lengths fall back to the full array dimension.
    always_comb begin
        eff_len_in = len;
        if ((len == '0) || (len > LEN_W'(MATRIX_WIDTH))) begin
            eff_len_in = LEN_W'(MATRIX_WIDTH);
        end
    end

    always_comb begin
        load_hit = '0;
        wrap_evt = '0;
        armed_d  = armed_q;
        wrap_d   = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            base_d[c]    = base_q[c];
            len_d[c]     = len_q[c];
            ctr_d[c]     = ctr_q[c];
            // Modulo arithmetic: a base near the top of the range wraps past zero.
            last_addr[c] = base_q[c] + CW'(len_q[c]) - CW'(1);
            load_hit[c]  = load && (load_ch == LCH_W'(c));

            if (clear) begin
                ctr_d[c]   = '0;
                armed_d[c] = 1'b0;
            end else if (load_hit[c]) begin
                base_d[c]  = start_val;
                len_d[c]   = eff_len_in;
                ctr_d[c]   = start_val;
                armed_d[c] = 1'b1;
            end else if (armed_q[c]) begin
                if (enable) begin
                    if (ctr_q[c] == last_addr[c]) begin
                        ctr_d[c]    = base_q[c];
                        wrap_d[c]   = 1'b1;
                        wrap_evt[c] = 1'b1;
                    end else begin
                        ctr_d[c] = ctr_q[c] + CW'(1);
                    end
                end
            end else begin
                ctr_d[c] = '0;
            end
        end
    end

`ifdef ACC_ADDR_GEN_WRAP_CNT_EN
    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            cnt_d[c] = cnt_q[c];
            if (clear || load_hit[c]) begin
                cnt_d[c] = '0;
            end else if (wrap_evt[c] && (cnt_q[c] != 16'hFFFF)) begin
                cnt_d[c] = cnt_q[c] + 16'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                cnt_q[c] <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                cnt_q[c] <= cnt_d[c];
            end
        end
    end

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            wrap_cnt[c*16 +: 16] = cnt_q[c];
        end
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                base_q[c] <= '0;
                len_q[c]  <= '0;
                ctr_q[c]  <= '0;
            end
            armed_q <= '0;
            wrap_q  <= '0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                base_q[c] <= base_d[c];
                len_q[c]  <= len_d[c];
                ctr_q[c]  <= ctr_d[c];
            end
            armed_q <= armed_d;
            wrap_q  <= wrap_d;
        end
    end

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            ctr_val[c*CW +: CW] = ctr_q[c];
        end
    end

    assign armed = armed_q;
    assign wrap  = wrap_q;

endmodule

// File: tb/tb_acc_addr_gen.sv
// Bench for acc_addr_gen (NUM_CH=2): sequence-index reference model feeding an expected queue,
// per-cycle comparison on the falling edge, plus hand-computed literal checks.
module tb_acc_addr_gen;

    localparam int CW    = 32;
    localparam int MW    = 14;
    localparam int NCH   = 2;
    localparam int LCH_W = 1;
    localparam int LEN_W = 5;
`ifdef ACC_ADDR_GEN_WRAP_CNT_EN
    localparam int W = NCH*CW + 2*NCH + 16*NCH;
`else
    localparam int W = NCH*CW + 2*NCH;
`endif

    logic                  clk;
    logic                  rst;
    logic                  enable;
    logic                  clear;
    logic                  load;
    logic [LCH_W-1:0]      load_ch;
    logic [CW-1:0]         start_val;
    logic [LEN_W-1:0]      len;
    logic [NCH*CW-1:0]     ctr_val;
    logic [NCH-1:0]        armed;
    logic [NCH-1:0]        wrap;
`ifdef ACC_ADDR_GEN_WRAP_CNT_EN
    logic [NCH*16-1:0]     wrap_cnt;
`endif

    acc_addr_gen #(
        .COUNTER_WIDTH(CW),
        .MATRIX_WIDTH (MW),
        .NUM_CH       (NCH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .clear    (clear),
        .load     (load),
        .load_ch  (load_ch),
        .start_val(start_val),
        .len      (len),
        .ctr_val  (ctr_val),
        .armed    (armed),
`ifdef ACC_ADDR_GEN_WRAP_CNT_EN
        .wrap_cnt (wrap_cnt),
`endif
        .wrap     (wrap)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // reference model: each armed channel walks an index 0..eff-1, address = base + index
    logic [CW-1:0] m_base  [NCH];
    int            m_eff   [NCH];
    int            m_idx   [NCH];
    bit            m_armed [NCH];
    bit            m_wrap  [NCH];
    int            m_cnt   [NCH];

    logic [W-1:0] exp_q[$];
    logic [W-1:0] exp_e;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s at %0t: got=%0h expected=%0h", name, $time, got, exp);
        end
    endtask

    function automatic void model_reset();
        for (int ch = 0; ch < NCH; ch++) begin
            m_base[ch]  = '0;
            m_eff[ch]   = 0;
            m_idx[ch]   = 0;
            m_armed[ch] = 1'b0;
            m_wrap[ch]  = 1'b0;
            m_cnt[ch]   = 0;
        end
    endfunction

    function automatic void model_step();
        if (!rst) begin
            model_reset();
            return;
        end
        for (int ch = 0; ch < NCH; ch++) begin
            if (clear) begin
                m_armed[ch] = 1'b0;
                m_wrap[ch]  = 1'b0;
                m_idx[ch]   = 0;
                m_cnt[ch]   = 0;
            end else if (load && int'(load_ch) == ch) begin
                m_base[ch]  = start_val;
                m_eff[ch]   = (len == 0 || int'(len) > MW) ? MW : int'(len);
                m_idx[ch]   = 0;
                m_armed[ch] = 1'b1;
                m_wrap[ch]  = 1'b0;
                m_cnt[ch]   = 0;
            end else if (m_armed[ch] && enable) begin
                m_idx[ch]  = (m_idx[ch] + 1) % m_eff[ch];
                m_wrap[ch] = (m_idx[ch] == 0);
                if (m_wrap[ch] && m_cnt[ch] < 65535) m_cnt[ch]++;
            end else begin
                m_wrap[ch] = 1'b0;
            end
        end
    endfunction

    function automatic logic [W-1:0] snapshot();
        logic [NCH*CW-1:0] c;
        logic [NCH-1:0]    a;
        logic [NCH-1:0]    w;
`ifdef ACC_ADDR_GEN_WRAP_CNT_EN
        logic [NCH*16-1:0] n;
`endif
        for (int ch = 0; ch < NCH; ch++) begin
            c[ch*CW +: CW] = m_armed[ch] ? (m_base[ch] + CW'(m_idx[ch])) : '0;
            a[ch] = m_armed[ch];
            w[ch] = m_wrap[ch];
`ifdef ACC_ADDR_GEN_WRAP_CNT_EN
            n[ch*16 +: 16] = 16'(m_cnt[ch]);
`endif
        end
`ifdef ACC_ADDR_GEN_WRAP_CNT_EN
        return {n, c, a, w};
`else
        return {c, a, w};
`endif
    endfunction

    // driver tasks
    task automatic step();
        @(posedge clk);
        model_step();
        exp_q.push_back(snapshot());
        #1;
    endtask

    task automatic cyc(input logic en, input logic clr, input logic ld, input logic ch,
                       input logic [31:0] sv, input logic [4:0] ln);
        enable    = en;
        clear     = clr;
        load      = ld;
        load_ch   = ch;
        start_val = sv;
        len       = ln;
        step();
    endtask

    // scoreboard compare: one expected snapshot per clock, checked on the falling edge
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_e = exp_q.pop_front();
            check("cmp_wrap",  64'(wrap),    64'(exp_e[1:0]));
            check("cmp_armed", 64'(armed),   64'(exp_e[3:2]));
            check("cmp_ctr",   64'(ctr_val), 64'(exp_e[67:4]));
`ifdef ACC_ADDR_GEN_WRAP_CNT_EN
            check("cmp_wrap_cnt", 64'(wrap_cnt), 64'(exp_e[99:68]));
`endif
        end
    end

    logic [31:0] seq033 [4];
    logic [31:0] seq034 [3];
    logic [4:0]  lens035 [2];

    initial begin
        seq033  = '{32'd101, 32'd102, 32'd103, 32'd100};
        seq034  = '{32'hFFFF_FFFF, 32'h0000_0000, 32'hFFFF_FFFE};
        lens035 = '{5'd0, 5'd20};
        model_reset();
        rst = 1'b0; enable = 0; clear = 0; load = 0; load_ch = 0; start_val = 0; len = 0;

        // reset state
        step();
        step();
        check("reset_ctr",   64'(ctr_val), 64'd0);
        check("reset_armed", 64'(armed),   64'd0);
        check("reset_wrap",  64'(wrap),    64'd0);
        rst = 1'b1;

        // base 100, length 4, continuous enable
        cyc(0, 0, 1, 0, 32'd100, 5'd4);
        check("load_c0",    64'(ctr_val[31:0]),  64'd100);
        check("load_c1",    64'(ctr_val[63:32]), 64'd0);
        check("load_armed", 64'(armed),          64'b01);
        for (int i = 0; i < 4; i++) begin
            cyc(1, 0, 0, 0, 0, 0);
            check("seq_c0", 64'(ctr_val[31:0]), 64'(seq033[i]));
            check("seq_wrap", 64'(wrap), (i == 3) ? 64'b01 : 64'b00);
        end
        cyc(0, 0, 0, 0, 0, 0);
        check("hold_c0",   64'(ctr_val[31:0]), 64'd100);
        check("hold_wrap", 64'(wrap),          64'd0);

        // modulo wrap near the top of the address range
        cyc(0, 0, 1, 1, 32'hFFFF_FFFE, 5'd3);
        check("top_load_c1", 64'(ctr_val[63:32]), 64'hFFFF_FFFE);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 0, 0, 0, 0);
            check("top_c1", 64'(ctr_val[63:32]), 64'(seq034[i]));
        end
        check("top_wrap", 64'(wrap), 64'b10);

        cyc(0, 1, 0, 0, 0, 0);
        check("clear_all", 64'(ctr_val), 64'd0);
        check("clear_armed", 64'(armed), 64'd0);

        // zero and oversize lengths both use the full 14-entry sequence
        for (int k = 0; k < 2; k++) begin
            cyc(0, 0, 1, 0, 32'd0, lens035[k]);
            for (int i = 0; i < 13; i++) cyc(1, 0, 0, 0, 0, 0);
            check("full_len_13", 64'(ctr_val[31:0]), 64'd13);
            check("full_len_nowrap", 64'(wrap), 64'd0);
            cyc(1, 0, 0, 0, 0, 0);
            check("full_len_back", 64'(ctr_val[31:0]), 64'd0);
            check("full_len_wrap", 64'(wrap), 64'b01);
        end

        // load versus enable in the same cycle, then clear over load
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 32'd100, 5'd4);
        cyc(1, 0, 1, 1, 32'd200, 5'd8);
        check("mix_c0_a", 64'(ctr_val[31:0]),  64'd101);
        check("mix_c1_a", 64'(ctr_val[63:32]), 64'd200);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 1, 0, 32'd50, 5'd4);
        check("mix_c0_b", 64'(ctr_val[31:0]),  64'd50);
        check("mix_c1_b", 64'(ctr_val[63:32]), 64'd202);
        cyc(1, 1, 1, 1, 32'd7, 5'd3);
        check("clr_over_load_ctr",   64'(ctr_val), 64'd0);
        check("clr_over_load_armed", 64'(armed),   64'd0);

        // length 1: wraps on every enabled cycle
        cyc(0, 0, 1, 0, 32'd7, 5'd1);
        for (int i = 0; i < 3; i++) begin
            cyc(1, 0, 0, 0, 0, 0);
            check("len1_c0",   64'(ctr_val[31:0]), 64'd7);
            check("len1_wrap", 64'(wrap),          64'b01);
        end

        // asynchronous reset mid-count
        cyc(0, 0, 1, 1, 32'd10, 5'd5);
        cyc(1, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0);
        check("pre_rst_c1", 64'(ctr_val[63:32]), 64'd12);
        #2;
        rst = 1'b0;
        model_reset();
        exp_q.delete();
        exp_q.push_back(snapshot());
        #1;
        check("async_rst_ctr",   64'(ctr_val), 64'd0);
        check("async_rst_armed", 64'(armed),   64'd0);
        check("async_rst_wrap",  64'(wrap),    64'd0);
        step();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 0);
        check("post_rst_armed", 64'(armed),   64'd0);
        check("post_rst_ctr",   64'(ctr_val), 64'd0);
        cyc(0, 0, 1, 0, 32'd5, 5'd2);
        cyc(1, 0, 0, 0, 0, 0);
        check("post_rst_c0_a", 64'(ctr_val[31:0]), 64'd6);
        cyc(1, 0, 0, 0, 0, 0);
        check("post_rst_c0_b", 64'(ctr_val[31:0]), 64'd5);
        check("post_rst_wrap", 64'(wrap),          64'b01);

`ifdef ACC_ADDR_GEN_WRAP_CNT_EN
        // wrap counter saturation and clear on reload
        cyc(0, 1, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 32'd0, 5'd1);
        for (int i = 0; i < 3; i++) cyc(1, 0, 0, 0, 0, 0);
        check("wcnt_3", 64'(wrap_cnt[15:0]), 64'd3);
        for (int i = 0; i < 70000; i++) cyc(1, 0, 0, 0, 0, 0);
        check("wcnt_sat", 64'(wrap_cnt[15:0]), 64'hFFFF);
        cyc(0, 0, 1, 0, 32'd0, 5'd1);
        check("wcnt_reload", 64'(wrap_cnt[15:0]), 64'd0);
`endif

        cyc(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
